alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 32, data path width in bits; legal values 8..64.
REQ-002 Parameter SLT_SIGNED, default 1; when 1, op SLT compares two's-complement, otherwise unsigned.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  operation request, sampled on clk while busy=0.
REQ-006 ALUctr  input  4  operation select: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLTU, 0110 SUB, 0111 SLT, 1000 MULTU, 1001 DIVU; other codes are reserved.
REQ-007 busA, busB  input  WIDTH each  operands.
REQ-008 busy  output  1  high while a multi-cycle operation runs.
REQ-009 done  output  1  one-cycle pulse when busC/hi/flags are valid.
REQ-010 busC  output  WIDTH  result, or low half of product, or quotient.
REQ-011 hi  output  WIDTH  high half of product, or remainder; zero for single-cycle ops.
REQ-012 zero  output  1  high when busC equals 0.
REQ-013 ovf  output  1  signed overflow for ADD/SUB; 0 for all other ops.
REQ-014 dz  output  1  divide-by-zero flag; meaningful only for DIVU.

Function
REQ-015 The FSM has three states: IDLE, RUN and DONE.
REQ-016 Single-cycle ops: start in IDLE goes to DONE; done=1 for the next cycle with registered results (latency 1); then back to IDLE.
REQ-017 MULTU/DIVU: start in IDLE latches operands, sets busy=1 and goes to RUN.
REQ-018 In RUN, one shift-add or restoring-subtract step per cycle for exactly WIDTH cycles, counted by a down-counter of width clog2(WIDTH+1).
REQ-019 After the last RUN step, the FSM goes to DONE and busy=0; total latency from start to done is WIDTH+1 cycles.
REQ-020 start while busy=1, or while in DONE, is ignored: no queuing and no effect on the running operation.
REQ-021 start may be asserted in the cycle done=1 is high; it is accepted the following cycle (from IDLE).
REQ-022 Outputs busC, hi, zero, ovf and dz hold their values until the next done; they do not change during RUN.
REQ-023 ADD/SUB wrap modulo 2^WIDTH; ovf = (sign of A equals sign of the effective B) AND (sign of result differs from sign of A).
REQ-024 SLT/SLTU write busC=1 or 0 (zero-extended) and hi=0.
REQ-025 MULTU: {hi,busC} is the unsigned 2*WIDTH-bit product of busA and busB.
REQ-026 DIVU with busB≠0: busC is the quotient and hi the remainder, unsigned.
REQ-027 DIVU with busB=0: dz=1, busC all ones, hi=busA; latency is still WIDTH+1.
REQ-028 A reserved ALUctr code completes as a single-cycle op with busC=0, hi=0 and zero=1.
REQ-029 zero is computed on the final busC for every op, including MULTU (low half only).

Reset
REQ-030 rst_n low immediately forces IDLE, busy=0, done=0, busC=0, hi=0, zero=1, ovf=0, dz=0 and counter=0.
REQ-031 Reset asserted during RUN aborts the operation: no done pulse and no partial result visible.
REQ-032 The first start is accepted on the first rising edge after rst_n deasserts.

Structure
REQ-033 Shared package alu_pkg holds the ALUctr encodings, the state enum {IDLE, RUN, DONE} and the localparam for the counter width function.
REQ-034 The iterative datapath is one sub-module, alu_muldiv_seq, with ports load, op_div, step and the result registers; alu_mc owns the FSM and the single-cycle ops.

Verification
REQ-035 WIDTH=32, ADD 0x7FFFFFFF+1 -> done 1 cycle after start, busC=0x80000000, ovf=1, zero=0.
REQ-036 SUB 5-5 -> busC=0, zero=1, ovf=0; SLT with SLT_SIGNED=1, busA=0xFFFFFFFF, busB=1 -> busC=1; SLTU with the same operands -> busC=0.
REQ-037 MULTU 0xFFFFFFFF*0xFFFFFFFF -> done exactly 33 cycles after start, hi=0xFFFFFFFE, busC=0x00000001; busy high for 32 cycles.
REQ-038 DIVU 100/7 -> busC=14, hi=2, dz=0; DIVU 100/0 -> dz=1, busC=0xFFFFFFFF, hi=100.
REQ-039 start pulses during RUN of a MULTU -> ignored, single done with the original product; reset pulse mid-RUN -> all outputs at reset values, no done, next op correct.
REQ-040 WIDTH=8, DIVU 0xFF/0x10 -> busC=0x0F, hi=0x0F, done 9 cycles after start.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode encodings, FSM states
// and the iteration-counter width helper.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SLTU  = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  // Counter must hold the value WIDTH itself, hence WIDTH+1.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) datapath,
// one step per cycle; hi/lo double as accumulator/remainder and multiplier/quotient.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             op_div,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo_q,
  output logic [WIDTH-1:0] hi_q,
  output logic [WIDTH-1:0] lo_nxt,
  output logic [WIDTH-1:0] hi_nxt,
  output logic             dz_q
);

  logic [WIDTH-1:0] lo_d, hi_d, m_q, m_d;
  logic             div_q, div_d, dz_d;
  logic [WIDTH:0]   sum, sh;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    sh   = {hi_q, lo_q[WIDTH-1]};
    ge   = sh >= {1'b0, m_q};
    // When ge holds the true difference fits in WIDTH bits.
    diff = sh[WIDTH-1:0] - m_q;
    if (div_q) begin
      hi_nxt = ge ? diff : sh[WIDTH-1:0];
      lo_nxt = {lo_q[WIDTH-2:0], ge};
    end else begin
      hi_nxt = sum[WIDTH:1];
      lo_nxt = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    lo_d  = lo_q;
    hi_d  = hi_q;
    m_d   = m_q;
    div_d = div_q;
    dz_d  = dz_q;
    if (load) begin
      lo_d  = a;
      hi_d  = '0;
      m_d   = b;
      div_d = op_div;
      dz_d  = op_div && (b == '0);
    end else if (step) begin
      lo_d = lo_nxt;
      hi_d = hi_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q  <= '0;
      hi_q  <= '0;
      m_q   <= '0;
      div_q <= 1'b0;
      dz_q  <= 1'b0;
    end else begin
      lo_q  <= lo_d;
      hi_q  <= hi_d;
      m_q   <= m_d;
      div_q <= div_d;
      dz_q  <= dz_d;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative MULTU/DIVU.
// Result registers update only on entry to DONE, so they hold between operations.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit SLT_SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       ALUctr,
  input  logic [WIDTH-1:0] busA,
  input  logic [WIDTH-1:0] busB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] busC,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             ovf,
  output logic             dz
);

  localparam int CW = cnt_w(WIDTH);

  alu_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] busc_q, busc_d, hi_q, hi_d;
  logic             zero_q, zero_d, ovf_q, ovf_d, dz_q, dz_d;
  logic             load, step, is_seq, slt;
  logic [WIDTH-1:0] sc_c, md_lo_q, md_hi_q, md_lo_nxt, md_hi_nxt;
  logic             sc_ovf, md_dz;

  alu_muldiv_seq #(.WIDTH(WIDTH)) u_seq (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .op_div (ALUctr == OP_DIVU),
    .step   (step),
    .a      (busA),
    .b      (busB),
    .lo_q   (md_lo_q),
    .hi_q   (md_hi_q),
    .lo_nxt (md_lo_nxt),
    .hi_nxt (md_hi_nxt),
    .dz_q   (md_dz)
  );

  always_comb begin
    slt    = SLT_SIGNED ? ($signed(busA) < $signed(busB)) : (busA < busB);
    sc_c   = '0;
    sc_ovf = 1'b0;
    case (ALUctr)
      OP_AND:  sc_c = busA & busB;
      OP_OR:   sc_c = busA | busB;
      OP_XOR:  sc_c = busA ^ busB;
      OP_ADD: begin
        sc_c   = busA + busB;
        sc_ovf = (busA[WIDTH-1] == busB[WIDTH-1]) && (sc_c[WIDTH-1] != busA[WIDTH-1]);
      end
      OP_SUB: begin
        // Effective B is ~B, so its sign is the inverse of busB's.
        sc_c   = busA - busB;
        sc_ovf = (busA[WIDTH-1] != busB[WIDTH-1]) && (sc_c[WIDTH-1] != busA[WIDTH-1]);
      end
      OP_SLTU: sc_c = WIDTH'(busA < busB);
      OP_SLT:  sc_c = WIDTH'(slt);
      default: ;
    endcase
  end

  assign is_seq = (ALUctr == OP_MULTU) || (ALUctr == OP_DIVU);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busc_d  = busc_q;
    hi_d    = hi_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_seq) begin
            load    = 1'b1;
            cnt_d   = CW'(WIDTH);
            state_d = RUN;
          end else begin
            busc_d  = sc_c;
            hi_d    = '0;
            zero_d  = (sc_c == '0);
            ovf_d   = sc_ovf;
            dz_d    = 1'b0;
            state_d = DONE;
          end
        end
      end
      RUN: begin
        step  = 1'b1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          busc_d  = md_lo_nxt;
          hi_d    = md_hi_nxt;
          zero_d  = (md_lo_nxt == '0);
          ovf_d   = 1'b0;
          dz_d    = md_dz;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busc_q  <= '0;
      hi_q    <= '0;
      zero_q  <= 1'b1;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busc_q  <= busc_d;
      hi_q    <= hi_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign busC = busc_q;
  assign hi   = hi_q;
  assign zero = zero_q;
  assign ovf  = ovf_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed corner cases plus random ops on a
// 32-bit and an 8-bit instance, checked against an arithmetic reference model.
module tb_alu_mc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        s32 = 1'b0, s8 = 1'b0;
  logic [3:0]  ctr32 = '0, ctr8 = '0;
  logic [31:0] a32 = '0, b32 = '0, c32, h32;
  logic [7:0]  a8 = '0, b8 = '0, c8, h8;
  logic        busy32, done32, z32, o32, d32;
  logic        busy8, done8, z8, o8, d8;

  alu_mc dut (
    .clk(clk), .rst_n(rst_n), .start(s32), .ALUctr(ctr32), .busA(a32), .busB(b32),
    .busy(busy32), .done(done32), .busC(c32), .hi(h32), .zero(z32), .ovf(o32), .dz(d32)
  );

  alu_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .ALUctr(ctr8), .busA(a8), .busB(b8),
    .busy(busy8), .done(done8), .busC(c8), .hi(h8), .zero(z8), .ovf(o8), .dz(d8)
  );

  int tests = 0;
  int fails = 0;
  bit sel8 = 1'b0;
  logic [63:0] prev_c [2];

  logic [63:0] ob_c, ob_h;
  logic        ob_busy, ob_done, ob_z, ob_o, ob_d;
  always_comb begin
    if (sel8) begin
      ob_c = {56'd0, c8}; ob_h = {56'd0, h8};
      ob_busy = busy8; ob_done = done8; ob_z = z8; ob_o = o8; ob_d = d8;
    end else begin
      ob_c = {32'd0, c32}; ob_h = {32'd0, h32};
      ob_busy = busy32; ob_done = done32; ob_z = z32; ob_o = o32; ob_d = d32;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    if (sel8) begin s8 = s; ctr8 = op; a8 = a[7:0]; b8 = b[7:0]; end
    else      begin s32 = s; ctr32 = op; a32 = a[31:0]; b32 = b[31:0]; end
  endtask

  // Reference: values treated as integers of width w, results from plain arithmetic.
  task automatic ref_model(input int w, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                           output logic [63:0] c, output logic [63:0] h, output logic o,
                           output logic d, output int lat);
    logic [63:0] mask;
    longint sa, sb, r, maxv, minv;
    mask = (64'd1 << w) - 64'd1;
    sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
    sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
    maxv = (longint'(1) << (w-1)) - 1;
    minv = -(longint'(1) << (w-1));
    c = 0; h = 0; o = 0; d = 0; lat = 1;
    case (op)
      4'b0000: c = a & b;
      4'b0001: c = a | b;
      4'b0011: c = a ^ b;
      4'b0010: begin r = sa + sb; c = 64'(r) & mask; o = (r > maxv) || (r < minv); end
      4'b0110: begin r = sa - sb; c = 64'(r) & mask; o = (r > maxv) || (r < minv); end
      4'b0100: c = (a < b) ? 1 : 0;
      4'b0111: c = (sa < sb) ? 1 : 0;
      4'b1000: begin c = (a * b) & mask; h = (a * b) >> w; lat = w + 1; end
      4'b1001: begin
        lat = w + 1;
        if (b == 0) begin c = mask; h = a; d = 1; end
        else begin c = a / b; h = a % b; end
      end
      default: ;
    endcase
  endtask

  // Caller is at a negedge; start is presented immediately.
  task automatic run_op(input int w, input logic [3:0] op, input logic [63:0] a_in,
                        input logic [63:0] b_in, input bit poke);
    logic [63:0] a, b, ec, eh, mask;
    logic eo, ed;
    int elat, lat, nbusy;
    bit seen;
    sel8 = (w == 8);
    mask = (64'd1 << w) - 64'd1;
    a = a_in & mask;
    b = b_in & mask;
    ref_model(w, op, a, b, ec, eh, eo, ed, elat);
    drive(1'b1, op, a, b);
    @(negedge clk);
    drive(1'b0, 4'h0, {$urandom, $urandom}, {$urandom, $urandom});
    lat = 1; nbusy = 0;
    if (elat > 1) chk("hold_during_run", ob_c, prev_c[sel8]);
    while (!ob_done && lat < 200) begin
      if (ob_busy) nbusy++;
      if (poke && lat == 5) drive(1'b1, 4'b0010, 64'd1, 64'd1);
      if (poke && lat == 7) drive(1'b1, 4'b1001, 64'd9, 64'd0);
      if (poke && (lat == 6 || lat == 8)) drive(1'b0, 4'h0, 64'd0, 64'd0);
      @(negedge clk);
      lat++;
    end
    chk($sformatf("latency w%0d op%0h", w, op), 64'(lat), 64'(elat));
    chk("busy_cycles", 64'(nbusy), 64'(elat - 1));
    chk($sformatf("busC w%0d op%0h", w, op), ob_c, ec);
    chk($sformatf("hi w%0d op%0h", w, op), ob_h, eh);
    chk("zero", 64'(ob_z), 64'(ec == 0));
    chk("ovf", 64'(ob_o), 64'(eo));
    chk("dz", 64'(ob_d), 64'(ed));
    prev_c[sel8] = ec;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ob_done) seen = 1'b1;
    end
    chk("done_single_pulse", 64'(seen), 64'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busC"}, ob_c, 64'd0);
    chk({tag, "_hi"}, ob_h, 64'd0);
    chk({tag, "_flags"}, {59'd0, ob_busy, ob_done, ob_z, ob_o, ob_d}, 64'b00100);
  endtask

  initial begin
    bit seen;
    logic [63:0] ra, rb;
    logic [3:0] rop;
    prev_c[0] = 0;
    prev_c[1] = 0;
    #12;
    sel8 = 1'b0; #1; chk_reset_vals("reset32");
    sel8 = 1'b1; #1; chk_reset_vals("reset8");
    @(negedge clk);
    rst_n = 1'b1;
    // First start accepted right after reset release.
    run_op(32, 4'b0010, 64'h7FFFFFFF, 64'h1, 0);
    run_op(32, 4'b0110, 64'd5, 64'd5, 0);
    run_op(32, 4'b0110, 64'h80000000, 64'd1, 0);
    run_op(32, 4'b0111, 64'hFFFFFFFF, 64'd1, 0);
    run_op(32, 4'b0100, 64'hFFFFFFFF, 64'd1, 0);
    run_op(32, 4'b1000, 64'hFFFFFFFF, 64'hFFFFFFFF, 0);
    run_op(32, 4'b1001, 64'd100, 64'd7, 0);
    run_op(32, 4'b1001, 64'd100, 64'd0, 0);
    run_op(32, 4'b1101, 64'h1234, 64'h5678, 0);
    run_op(32, 4'b1000, 64'h12345678, 64'h9ABCDEF0, 1);
    run_op(8, 4'b1001, 64'hFF, 64'h10, 0);
    run_op(8, 4'b1000, 64'hFF, 64'hFF, 0);
    run_op(8, 4'b0010, 64'h80, 64'h80, 0);

    // Reset in the middle of a multiply aborts it.
    sel8 = 1'b0;
    drive(1'b1, 4'b1000, 64'h5, 64'h7);
    @(negedge clk);
    drive(1'b0, 4'h0, 64'd0, 64'd0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("reset_mid_run");
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done32 || done8) seen = 1'b1;
    end
    chk("no_done_after_abort", 64'(seen), 64'd0);
    prev_c[0] = 0;
    prev_c[1] = 0;
    run_op(32, 4'b1000, 64'd6, 64'd7, 0);

    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra = {32'd0, $urandom};
      rb = ($urandom_range(0, 7) == 0) ? 64'd0 : {32'd0, $urandom >> $urandom_range(0, 31)};
      run_op(32, rop, ra, rb, 0);
    end
    for (int i = 0; i < 20; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra = 64'($urandom_range(0, 255));
      rb = 64'($urandom_range(0, 255));
      run_op(8, rop, ra, rb, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
